// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop
// on device clocks, then ACK check. Pads are open-drain: pad = oe ? 1'b0 : 1'bz.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int FILTER_LEN     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);

  // IDLE wait byte | INHIBIT clk low | REQ start bit | SEND bits on falls | ACK | WAIT_IDLE bus free
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_f_dly_q, clk_f_dly_d;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d, ok_q, ok_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tx_ready_q, tx_ready_d, busy_q, busy_d;
  logic          done_q, done_d, err_q, err_d, to_q, to_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          fall;

  // A filtered line follows the synchronised one only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_s1_d    = PS2_CLK;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = PS2_DAT;
    dat_s2_d    = dat_s1_q;
    clk_f_d     = clk_f_q;
    dat_f_d     = dat_f_q;
    clk_fcnt_d  = '0;
    dat_fcnt_d  = '0;
    clk_f_dly_d = clk_f_q;
    if (clk_s2_q != clk_f_q) begin
      if (clk_fcnt_q == FILTER_LAST) clk_f_d = clk_s2_q;
      else                           clk_fcnt_d = clk_fcnt_q + FW'(1);
    end
    if (dat_s2_q != dat_f_q) begin
      if (dat_fcnt_q == FILTER_LAST) dat_f_d = dat_s2_q;
      else                           dat_fcnt_d = dat_fcnt_q + FW'(1);
    end
  end

  assign fall = clk_f_dly_q & ~clk_f_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    ok_d     = ok_q;
    bitcnt_d = bitcnt_q;
    tmr_d    = tmr_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          data_d   = tx_data;
          par_d    = ~^tx_data;
          bitcnt_d = '0;
          tmr_d    = INHIBIT_LOAD;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr_q == '0) begin
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_REQ: begin
        tmr_d   = TIMEOUT_LOAD;
        state_d = S_SEND;
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (tmr_q == '0) begin
          to_d     = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
          if (state_q == S_SEND) begin
            if (fall) begin
              bitcnt_d = bitcnt_q + 4'd1;
              if (bitcnt_q < 4'd8) begin
                dat_oe_d = ~data_q[bitcnt_q[2:0]];
              end else if (bitcnt_q == 4'd8) begin
                dat_oe_d = ~par_q;
              end else begin
                dat_oe_d = 1'b0;
                state_d  = S_ACK;
              end
            end
          end else if (state_q == S_ACK) begin
            if (fall) begin
              ok_d    = ~dat_f_q;
              state_d = S_WAIT_IDLE;
            end
          end else if (clk_f_q && dat_f_q) begin
            done_d  = ok_q;
            err_d   = ~ok_q;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
    clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE) && !(done_d || err_d || to_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_f_q     <= 1'b1;
      dat_f_q     <= 1'b1;
      clk_f_dly_q <= 1'b1;
      clk_fcnt_q  <= '0;
      dat_fcnt_q  <= '0;
      state_q     <= S_IDLE;
      data_q      <= '0;
      par_q       <= 1'b0;
      ok_q        <= 1'b0;
      bitcnt_q    <= '0;
      tmr_q       <= '0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      clk_f_q     <= clk_f_d;
      dat_f_q     <= dat_f_d;
      clk_f_dly_q <= clk_f_dly_d;
      clk_fcnt_q  <= clk_fcnt_d;
      dat_fcnt_q  <= dat_fcnt_d;
      state_q     <= state_d;
      data_q      <= data_d;
      par_q       <= par_d;
      ok_q        <= ok_d;
      bitcnt_q    <= bitcnt_d;
      tmr_q       <= tmr_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      to_q        <= to_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign tx_ack_err = err_q;
  assign tx_timeout = to_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device-side BFM clocks frames out of the host and
// collects the bits it samples on rising device-clock edges.
module tb_ps2_host_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_ack_err, tx_timeout;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       bfm_clk = 1'b1, bfm_dat = 1'b1, glitch = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0, err_cnt = 0, to_cnt = 0;

  assign ps2_clk_line = bfm_clk & ~glitch & ~ps2_clk_oe;
  assign ps2_dat_line = bfm_dat & ~ps2_dat_oe;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES(100),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(20000)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout),
    .PS2_CLK(ps2_clk_line),
    .PS2_DAT(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // Pulse counters count high cycles, so a delta of exactly 1 also proves a 1-cycle pulse.
  always @(negedge CLOCK_50) begin
    if (tx_done)    done_cnt++;
    if (tx_ack_err) err_cnt++;
    if (tx_timeout) to_cnt++;
  end

  task automatic start_frame(input logic [7:0] b, output int inh, output int req);
    int w;
    w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge CLOCK_50);
      w++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 1000) begin
      inh++;
      @(negedge CLOCK_50);
    end
    req = 0;
    while (ps2_clk_oe && ps2_dat_oe && req < 10) begin
      req++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic bfm_frame(input bit ack_low, output logic [10:0] bits);
    bits = '0;
    repeat (50) @(negedge CLOCK_50);
    bits[0] = ps2_dat_line;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack_low) begin
        bfm_dat = 1'b0;
        repeat (20) @(negedge CLOCK_50);
      end
      bfm_clk = 1'b0;
      repeat (200) @(negedge CLOCK_50);
      bfm_clk = 1'b1;
      if (i <= 10) begin
        bits[i] = ps2_dat_line;
        repeat (200) @(negedge CLOCK_50);
      end else begin
        bfm_dat = 1'b1;
      end
    end
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    while (!(tx_done || tx_ack_err || tx_timeout) && cyc < 2000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    n_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); else n_pass++;
    n_total++; if (ps2_dat_oe !== 1'b0) $display("FAIL reset_dat_oe got=%b exp=0", ps2_dat_oe); else n_pass++;
    n_total++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done got=%b exp=0", tx_done); else n_pass++;
    n_total++; if (tx_ack_err !== 1'b0) $display("FAIL reset_ack_err got=%b exp=0", tx_ack_err); else n_pass++;
    n_total++; if (tx_timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", tx_timeout); else n_pass++;
  endtask

  task automatic test_frame_ed();
    int inh, req, cyc, d0, e0, t0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    start_frame(8'hED, inh, req);
    n_total++; if (inh != 100) $display("FAIL ed_inhibit_len got=%0d exp=100", inh); else n_pass++;
    n_total++; if (req != 1) $display("FAIL ed_req_len got=%0d exp=1", req); else n_pass++;
    bfm_frame(1'b1, bits);
    wait_pulse(cyc);
    @(negedge CLOCK_50);
    n_total++; if (bits !== 11'b11111011010) $display("FAIL ed_bits got=%b exp=11111011010", bits); else n_pass++;
    n_total++; if (cyc >= 2000) $display("FAIL ed_pulse_seen waited=%0d exp<2000", cyc); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL ed_done got=%0d exp=1", done_cnt - d0); else n_pass++;
    n_total++; if (err_cnt - e0 != 0) $display("FAIL ed_ack_err got=%0d exp=0", err_cnt - e0); else n_pass++;
    n_total++; if (to_cnt - t0 != 0) $display("FAIL ed_timeout got=%0d exp=0", to_cnt - t0); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL ed_ready_after got=%b exp=1", tx_ready); else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0] pats [3] = '{8'h00, 8'hFF, 8'h07};
    logic [10:0] bits, exp;
    int inh, req, cyc, d0;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      exp = {1'b1, ~^pats[k], pats[k], 1'b0};
      start_frame(pats[k], inh, req);
      bfm_frame(1'b1, bits);
      wait_pulse(cyc);
      @(negedge CLOCK_50);
      n_total++; if (bits !== exp) $display("FAIL parity_bits_%h got=%b exp=%b", pats[k], bits, exp); else n_pass++;
      n_total++; if (done_cnt - d0 != 1) $display("FAIL parity_done_%h got=%0d exp=1", pats[k], done_cnt - d0); else n_pass++;
    end
  endtask

  task automatic test_ack_err();
    int inh, req, cyc, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'h3C, inh, req);
    bfm_frame(1'b0, bits);
    wait_pulse(cyc);
    @(negedge CLOCK_50);
    n_total++; if (err_cnt - e0 != 1) $display("FAIL ackerr_pulse got=%0d exp=1", err_cnt - e0); else n_pass++;
    n_total++; if (done_cnt - d0 != 0) $display("FAIL ackerr_done got=%0d exp=0", done_cnt - d0); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL ackerr_ready_after got=%b exp=1", tx_ready); else n_pass++;
  endtask

  task automatic test_timeout();
    int inh, req, cnt, d0, e0, t0;
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    start_frame(8'hF4, inh, req);
    cnt = 0;
    while (!tx_timeout && cnt < 30000) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    n_total++; if (cnt != 20000) $display("FAIL timeout_cycles got=%0d exp=20000", cnt); else n_pass++;
    n_total++; if (ps2_clk_oe !== 1'b0) $display("FAIL timeout_clk_oe got=%b exp=0", ps2_clk_oe); else n_pass++;
    n_total++; if (ps2_dat_oe !== 1'b0) $display("FAIL timeout_dat_oe got=%b exp=0", ps2_dat_oe); else n_pass++;
    @(negedge CLOCK_50);
    n_total++; if (tx_ready !== 1'b1) $display("FAIL timeout_ready got=%b exp=1", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (to_cnt - t0 != 1) $display("FAIL timeout_pulse got=%0d exp=1", to_cnt - t0); else n_pass++;
    n_total++; if ((done_cnt - d0) + (err_cnt - e0) != 0) $display("FAIL timeout_other_pulses got=%0d exp=0", (done_cnt - d0) + (err_cnt - e0)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int inh, req, cyc, d0, e0, t0;
    logic [10:0] bits, exp;
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    start_frame(8'h55, inh, req);
    repeat (50) @(negedge CLOCK_50);
    for (int i = 1; i <= 3; i++) begin
      bfm_clk = 1'b0;
      repeat (200) @(negedge CLOCK_50);
      bfm_clk = 1'b1;
      repeat (200) @(negedge CLOCK_50);
    end
    bfm_clk = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    n_total++; if (ps2_dat_oe !== 1'b1) $display("FAIL midrst_bit3_drive got=%b exp=1", ps2_dat_oe); else n_pass++;
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    n_total++; if (ps2_clk_oe !== 1'b0) $display("FAIL midrst_clk_oe got=%b exp=0", ps2_clk_oe); else n_pass++;
    n_total++; if (ps2_dat_oe !== 1'b0) $display("FAIL midrst_dat_oe got=%b exp=0", ps2_dat_oe); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", tx_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
    bfm_clk = 1'b1;
    repeat (50) @(negedge CLOCK_50);
    n_total++; if ((done_cnt - d0) + (err_cnt - e0) + (to_cnt - t0) != 0) $display("FAIL midrst_no_pulse got=%0d exp=0", (done_cnt - d0) + (err_cnt - e0) + (to_cnt - t0)); else n_pass++;
    d0 = done_cnt;
    exp = {1'b1, ~^8'h55, 8'h55, 1'b0};
    start_frame(8'h55, inh, req);
    bfm_frame(1'b1, bits);
    wait_pulse(cyc);
    @(negedge CLOCK_50);
    n_total++; if (bits !== exp) $display("FAIL midrst_resend_bits got=%b exp=%b", bits, exp); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL midrst_resend_done got=%0d exp=1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_ignore_valid_glitch();
    int inh, req, cyc, d0, a0;
    logic [10:0] bits, exp;
    d0 = done_cnt;
    exp = {1'b1, ~^8'hA6, 8'hA6, 1'b0};
    start_frame(8'hA6, inh, req);
    fork
      bfm_frame(1'b1, bits);
      begin
        repeat (700) @(negedge CLOCK_50);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        repeat (400) @(negedge CLOCK_50);
        glitch = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        glitch = 1'b0;
      end
    join
    wait_pulse(cyc);
    @(negedge CLOCK_50);
    n_total++; if (bits !== exp) $display("FAIL ignore_bits got=%b exp=%b", bits, exp); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL ignore_done got=%0d exp=1", done_cnt - d0); else n_pass++;
    a0 = 0;
    repeat (300) begin
      @(negedge CLOCK_50);
      if (busy) a0++;
    end
    n_total++; if (a0 != 0) $display("FAIL ignore_no_second_frame busy_cycles=%0d exp=0", a0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_ignore_valid_glitch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
